// File: rtl/stack_cmp_pkg.sv
// Shared definitions for the operand-stack / comparison unit.
//   - Wasm opcode byte constants handled by the unit
//   - trap code constants (3-bit, sticky in the unit)
//   - FSM state encoding (exposed on the unit's debug port)
//   - comparison-kind enum consumed by cmp_core
//   - cmp_kind_of(): maps a compare opcode to its kind
package stack_cmp_pkg;

  localparam logic [7:0] OP_DROP      = 8'h1A;
  localparam logic [7:0] OP_I32_CONST = 8'h41;
  localparam logic [7:0] OP_I64_CONST = 8'h42;
  localparam logic [7:0] OP_I32_EQZ   = 8'h45;
  localparam logic [7:0] OP_I32_EQ    = 8'h46;
  localparam logic [7:0] OP_I32_NE    = 8'h47;
  localparam logic [7:0] OP_I32_LT_S  = 8'h48;
  localparam logic [7:0] OP_I32_LT_U  = 8'h49;
  localparam logic [7:0] OP_I32_GT_S  = 8'h4A;
  localparam logic [7:0] OP_I32_GT_U  = 8'h4B;
  localparam logic [7:0] OP_I32_LE_S  = 8'h4C;
  localparam logic [7:0] OP_I32_LE_U  = 8'h4D;
  localparam logic [7:0] OP_I32_GE_S  = 8'h4E;
  localparam logic [7:0] OP_I32_GE_U  = 8'h4F;
  localparam logic [7:0] OP_I64_EQZ   = 8'h50;
  localparam logic [7:0] OP_I64_EQ    = 8'h51;
  localparam logic [7:0] OP_I64_NE    = 8'h52;
  localparam logic [7:0] OP_I64_LT_S  = 8'h53;
  localparam logic [7:0] OP_I64_LT_U  = 8'h54;
  localparam logic [7:0] OP_I64_GT_S  = 8'h55;
  localparam logic [7:0] OP_I64_GT_U  = 8'h56;
  localparam logic [7:0] OP_I64_LE_S  = 8'h57;
  localparam logic [7:0] OP_I64_LE_U  = 8'h58;
  localparam logic [7:0] OP_I64_GE_S  = 8'h59;
  localparam logic [7:0] OP_I64_GE_U  = 8'h5A;

  localparam logic [2:0] TRAP_NONE      = 3'd0;
  localparam logic [2:0] TRAP_UNDERFLOW = 3'd1;
  localparam logic [2:0] TRAP_OVERFLOW  = 3'd2;
  localparam logic [2:0] TRAP_INVALID   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Order matches the opcode offset from the eqz opcode of each group.
  typedef enum logic [3:0] {
    CMP_EQZ  = 4'd0,
    CMP_EQ   = 4'd1,
    CMP_NE   = 4'd2,
    CMP_LT_S = 4'd3,
    CMP_LT_U = 4'd4,
    CMP_GT_S = 4'd5,
    CMP_GT_U = 4'd6,
    CMP_LE_S = 4'd7,
    CMP_LE_U = 4'd8,
    CMP_GE_S = 4'd9,
    CMP_GE_U = 4'd10
  } cmp_kind_t;

  // Only meaningful for 0x45..0x5A; anything else maps to EQZ and is
  // never used because such opcodes are not executed as compares.
  function automatic cmp_kind_t cmp_kind_of(input logic [7:0] op);
    logic [7:0] off;
    off = (op >= OP_I64_EQZ) ? op - OP_I64_EQZ : op - OP_I32_EQZ;
    if (off > 8'd10) return CMP_EQZ;
    return cmp_kind_t'(off[3:0]);
  endfunction

endpackage

// File: rtl/stack_cmp_unit_if.sv
// Request/response bundle between a requester (master) and
// stack_cmp_unit (slave).
//   op_valid/opcode/data_in : request from master
//   op_ready                : unit can accept
//   op_done                 : one-cycle retire pulse
//   result/result_empty/trap: top-of-stack view and sticky trap code
//
// Handshake: a request transfers on the rising edge where op_valid and
// op_ready are both 1. opcode/data_in need only be stable in that cycle.
// op_valid while op_ready is 0 is ignored (not queued). The unit drops
// op_ready for the following two cycles and pulses op_done in the second.
interface stack_cmp_unit_if #(
  parameter int WIDTH = 64
);
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] data_in;
  logic             op_done;
  logic [WIDTH-1:0] result;
  logic             result_empty;
  logic [2:0]       trap;

  modport master (
    output op_valid, opcode, data_in,
    input  op_ready, op_done, result, result_empty, trap
  );

  modport slave (
    input  op_valid, opcode, data_in,
    output op_ready, op_done, result, result_empty, trap
  );
endinterface

// File: rtl/cmp_core.sv
// Combinational Wasm comparison.
//   a, b  : operands (64-bit; only [31:0] used when is64=0)
//   kind  : comparison kind (EQZ tests a only)
//   is64  : 1 = 64-bit compare, 0 = 32-bit compare
//   res   : 1-bit result of a OP b
module cmp_core
  import stack_cmp_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  cmp_kind_t   kind,
  input  logic        is64,
  output logic        res
);

  logic        sgn;
  logic [64:0] ax;
  logic [64:0] bx;
  logic        eq;
  logic        lt;

  // Both operands are widened to 65 bits (sign- or zero-extended by
  // kind), so one signed comparator serves signed and unsigned kinds.
  always_comb begin
    sgn = kind inside {CMP_LT_S, CMP_GT_S, CMP_LE_S, CMP_GE_S};
    if (is64) begin
      ax = {sgn & a[63], a};
      bx = {sgn & b[63], b};
    end else begin
      ax = {{33{sgn & a[31]}}, a[31:0]};
      bx = {{33{sgn & b[31]}}, b[31:0]};
    end
    eq = (ax == bx);
    lt = ($signed(ax) < $signed(bx));

    res = 1'b0;
    case (kind)
      CMP_EQZ:            res = (ax == 65'd0);
      CMP_EQ:             res = eq;
      CMP_NE:             res = !eq;
      CMP_LT_S, CMP_LT_U: res = lt;
      CMP_GT_S, CMP_GT_U: res = !lt && !eq;
      CMP_LE_S, CMP_LE_U: res = lt || eq;
      CMP_GE_S, CMP_GE_U: res = !lt;
      default:            res = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_cmp_unit.sv
// Operand stack plus Wasm i32/i64 comparison engine.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low
//   bus       : stack_cmp_unit_if slave (request handshake, top-of-stack
//               result, sticky trap)
//   dbg_state : current FSM state
//   dbg_sp    : current stack pointer (0..DEPTH)
// WIDTH must be 32 or 64; DEPTH must be a power of two, at least 2.
// Each request takes IDLE -> EXEC -> DONE, i.e. one request per 3 cycles.
module stack_cmp_unit
  import stack_cmp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int SPW  = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset,
  stack_cmp_unit_if.slave bus,
  output state_t         dbg_state,
  output logic [SPW-1:0] dbg_sp
);

  localparam int             AW   = SPW - 1;
  localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

  state_t           state_q, state_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [2:0]       trap_q, trap_d;
  logic [7:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             is_const, is_drop, is_eqz, is_bin, is_i64, op_legal;
  logic [1:0]       need;
  logic [2:0]       exec_trap;
  logic [AW-1:0]    idx_top, idx_sec, idx_push;
  logic [WIDTH-1:0] top_val, sec_val, const_val;
  logic [63:0]      cmp_a, cmp_b;
  logic             cmp_res;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  // Ready is forced low while reset is held, even though state is IDLE.
  assign bus.op_ready = reset && (state_q == ST_IDLE) && (trap_q == TRAP_NONE);
  assign bus.op_done  = (state_q == ST_DONE);
  assign accept       = bus.op_valid && bus.op_ready;

  // Index arithmetic wraps in AW bits; wrapped indices only occur on
  // requests that trap, which never write.
  assign idx_top  = AW'(sp_q - SPW'(1));
  assign idx_sec  = AW'(sp_q - SPW'(2));
  assign idx_push = AW'(sp_q);
  assign top_val  = mem[idx_top];
  assign sec_val  = mem[idx_sec];

  assign bus.result       = (sp_q == '0) ? '0 : top_val;
  assign bus.result_empty = (sp_q == '0);
  assign bus.trap         = trap_q;
  assign dbg_state        = state_q;
  assign dbg_sp           = sp_q;

  // Decode of the latched opcode.
  always_comb begin
    is_const = (op_q == OP_I32_CONST) || (op_q == OP_I64_CONST);
    is_drop  = (op_q == OP_DROP);
    is_eqz   = (op_q == OP_I32_EQZ) || (op_q == OP_I64_EQZ);
    is_bin   = ((op_q >= OP_I32_EQ) && (op_q <= OP_I32_GE_U)) ||
               ((op_q >= OP_I64_EQ) && (op_q <= OP_I64_GE_U));
    is_i64   = (op_q == OP_I64_CONST) ||
               ((op_q >= OP_I64_EQZ) && (op_q <= OP_I64_GE_U));
    op_legal = (is_const || is_drop || is_eqz || is_bin) && !(is_i64 && (WIDTH == 32));

    need = 2'd0;
    if (is_bin) need = 2'd2;
    else if (is_drop || is_eqz) need = 2'd1;

    // Priority: INVALID, then UNDERFLOW, then OVERFLOW.
    exec_trap = TRAP_NONE;
    if (!op_legal) exec_trap = TRAP_INVALID;
    else if (sp_q < SPW'(need)) exec_trap = TRAP_UNDERFLOW;
    else if (is_const && (sp_q == FULL)) exec_trap = TRAP_OVERFLOW;

    const_val = (op_q == OP_I32_CONST) ? WIDTH'(data_q[31:0]) : data_q;
    // eqz tests the top entry; binary ops compute (second OP top).
    cmp_a = is_eqz ? 64'(top_val) : 64'(sec_val);
    cmp_b = 64'(top_val);
  end

  cmp_core u_cmp (
    .a    (cmp_a),
    .b    (cmp_b),
    .kind (cmp_kind_of(op_q)),
    .is64 (is_i64),
    .res  (cmp_res)
  );

  // Next state, stack pointer, trap and stack write port.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    trap_d  = trap_q;
    wr_en   = 1'b0;
    wr_idx  = idx_push;
    wr_data = const_val;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_DONE;
        if (exec_trap != TRAP_NONE) begin
          trap_d = exec_trap;
        end else if (is_const) begin
          wr_en = 1'b1;
          sp_d  = sp_q + SPW'(1);
        end else if (is_drop) begin
          sp_d = sp_q - SPW'(1);
        end else if (is_eqz) begin
          wr_en   = 1'b1;
          wr_idx  = idx_top;
          wr_data = WIDTH'(cmp_res);
        end else begin
          wr_en   = 1'b1;
          wr_idx  = idx_sec;
          wr_data = WIDTH'(cmp_res);
          sp_d    = sp_q - SPW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      trap_q  <= TRAP_NONE;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      trap_q  <= trap_d;
      if (accept) begin
        op_q   <= bus.opcode;
        data_q <= bus.data_in;
      end
    end
  end

  // Stack storage is not reset; sp==0 makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_stack_cmp_unit.sv
module tb_stack_cmp_unit;
  import stack_cmp_pkg::*;

  localparam int EXP_W  = 76;  // {trap[75:73], empty[72], sp[71:64], result[63:0]}
  localparam int MDEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_cmp_unit_if #(.WIDTH(64)) u64_if ();
  stack_cmp_unit_if #(.WIDTH(32)) u32_if ();
  state_t     st64, st32;
  logic [2:0] sp64, sp32;

  stack_cmp_unit #(.WIDTH(64), .DEPTH(MDEPTH)) dut64 (
    .clk(clk), .reset(reset), .bus(u64_if), .dbg_state(st64), .dbg_sp(sp64));
  stack_cmp_unit #(.WIDTH(32), .DEPTH(MDEPTH)) dut32 (
    .clk(clk), .reset(reset), .bus(u32_if), .dbg_state(st32), .dbg_sp(sp32));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [EXP_W-1:0] exp_q64[$];
  logic [EXP_W-1:0] exp_q32[$];

  logic [63:0] mstk [2][MDEPTH];
  int          msp  [2];
  logic [2:0]  mtrap[2];
  int          mwidth[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? u64_if.op_ready : u32_if.op_ready;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 0) ? u64_if.op_done : u32_if.op_done;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic ref_cmp(input int k, input logic [63:0] a, input logic [63:0] b,
                                   input bit wide);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub;
    ua = wide ? a : {32'b0, a[31:0]};
    ub = wide ? b : {32'b0, b[31:0]};
    sa = wide ? a : {{32{a[31]}}, a[31:0]};
    sb = wide ? b : {{32{b[31]}}, b[31:0]};
    case (k)
      0:  return ua == 64'd0;
      1:  return ua == ub;
      2:  return ua != ub;
      3:  return sa < sb;
      4:  return ua < ub;
      5:  return sa > sb;
      6:  return ua > ub;
      7:  return sa <= sb;
      8:  return ua <= ub;
      9:  return sa >= sb;
      10: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      msp[s]   = 0;
      mtrap[s] = 3'd0;
    end
  endtask

  task automatic model_step(input int sel, input logic [7:0] op, input logic [63:0] data);
    bit          cnst, drp, eqz, bin, wide, legal;
    int          need, k, p;
    logic [2:0]  t;
    logic [63:0] a, b, r, mask;
    cnst = 0; drp = 0; eqz = 0; bin = 0; wide = 0;
    mask = (mwidth[sel] == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (op == 8'h41) cnst = 1;
    else if (op == 8'h42) begin cnst = 1; wide = 1; end
    else if (op == 8'h1A) drp = 1;
    else if (op == 8'h45) eqz = 1;
    else if (op == 8'h50) begin eqz = 1; wide = 1; end
    else if (op >= 8'h46 && op <= 8'h4F) bin = 1;
    else if (op >= 8'h51 && op <= 8'h5A) begin bin = 1; wide = 1; end
    legal = (cnst || drp || eqz || bin) && !(wide && mwidth[sel] == 32);
    need  = bin ? 2 : ((drp || eqz) ? 1 : 0);
    k     = int'(op) - (wide ? 'h50 : 'h45);
    p     = msp[sel];
    t     = 3'd0;
    if (!legal) t = 3'd3;
    else if (p < need) t = 3'd1;
    else if (cnst && p == MDEPTH) t = 3'd2;
    if (t != 3'd0) begin
      mtrap[sel] = t;
    end else if (cnst) begin
      mstk[sel][p] = ((op == 8'h41) ? {32'b0, data[31:0]} : data) & mask;
      msp[sel] = p + 1;
    end else if (drp) begin
      msp[sel] = p - 1;
    end else if (eqz) begin
      a = mstk[sel][p-1];
      mstk[sel][p-1] = {63'b0, ref_cmp(0, a, 64'd0, wide)};
    end else begin
      a = mstk[sel][p-2];
      b = mstk[sel][p-1];
      mstk[sel][p-2] = {63'b0, ref_cmp(k, a, b, wide)};
      msp[sel] = p - 1;
    end
    r = (msp[sel] == 0) ? 64'd0 : mstk[sel][msp[sel]-1];
    if (sel == 0) exp_q64.push_back({mtrap[sel], msp[sel] == 0, 8'(msp[sel]), r});
    else          exp_q32.push_back({mtrap[sel], msp[sel] == 0, 8'(msp[sel]), r});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic v, input logic [7:0] op, input logic [63:0] data);
    if (sel == 0) begin
      u64_if.op_valid = v; u64_if.opcode = op; u64_if.data_in = data;
    end else begin
      u32_if.op_valid = v; u32_if.opcode = op; u32_if.data_in = data[31:0];
    end
  endtask

  // Issue one request; called away from the rising edge.
  task automatic do_op(input int sel, input logic [7:0] op, input logic [63:0] data);
    int n;
    n = 0;
    while (!rdy(sel) && n < 20) begin @(negedge clk); n++; end
    if (!rdy(sel)) begin
      check("ready_timeout", 64'(rdy(sel)), 64'd1);
      return;
    end
    drive(sel, 1'b1, op, data);
    @(posedge clk);
    model_step(sel, op, data);
    #1 drive(sel, 1'b0, 8'($urandom), {$urandom, $urandom});
    @(negedge clk);
    check("done_early", 64'(dn(sel)), 64'd0);
    check("ready_busy", 64'(rdy(sel)), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(dn(sel)), 64'd1);
    @(negedge clk);
    check("done_clear", 64'(dn(sel)), 64'd0);
    check("ready_back", 64'(rdy(sel)), 64'(mtrap[sel] == 3'd0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 8'h00, 64'd0);
    drive(1, 1'b0, 8'h00, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result64", u64_if.result, 64'd0);
    check("rst_empty64", 64'(u64_if.result_empty), 64'd1);
    check("rst_trap64", 64'(u64_if.trap), 64'd0);
    check("rst_ready64", 64'(u64_if.op_ready), 64'd0);
    check("rst_done64", 64'(u64_if.op_done), 64'd0);
    check("rst_result32", 64'(u32_if.result), 64'd0);
    check("rst_empty32", 64'(u32_if.result_empty), 64'd1);
    check("rst_ready32", 64'(u32_if.op_ready), 64'd0);
    reset = 1'b1;
    model_clear();
    #1;
    check("rel_ready64", 64'(u64_if.op_ready), 64'd1);
    check("rel_ready32", 64'(u32_if.op_ready), 64'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic compare_out(input int sel);
    logic [EXP_W-1:0] e;
    logic [63:0]      res_o;
    logic             emp_o;
    logic [2:0]       trap_o, sp_o;
    if (sel == 0) begin
      if (exp_q64.size() == 0) begin check("done64_unexpected", 64'd1, 64'd0); return; end
      e = exp_q64.pop_front();
      res_o = u64_if.result; emp_o = u64_if.result_empty; trap_o = u64_if.trap; sp_o = sp64;
    end else begin
      if (exp_q32.size() == 0) begin check("done32_unexpected", 64'd1, 64'd0); return; end
      e = exp_q32.pop_front();
      res_o = {32'b0, u32_if.result}; emp_o = u32_if.result_empty; trap_o = u32_if.trap; sp_o = sp32;
    end
    check(sel == 0 ? "result64" : "result32", res_o, e[63:0]);
    check(sel == 0 ? "empty64" : "empty32", 64'(emp_o), 64'(e[72]));
    check(sel == 0 ? "sp64" : "sp32", 64'(sp_o), 64'(e[71:64]));
    check(sel == 0 ? "trap64" : "trap32", 64'(trap_o), 64'(e[75:73]));
  endtask

  always @(negedge clk) begin
    if (u64_if.op_done) compare_out(0);
    if (u32_if.op_done) compare_out(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a, b;
    logic [7:0]  op;
    int          pick;
    mwidth[0] = 64;
    mwidth[1] = 32;
    model_clear();
    reset = 1'b0;
    drive(0, 1'b0, 8'h00, 64'd0);
    drive(1, 1'b0, 8'h00, 64'd0);
    apply_reset();

    // 32-bit instance: directed i32 compare, random i32 ops, then an i64
    // opcode on an empty stack must report INVALID ahead of UNDERFLOW.
    do_op(1, 8'h41, 64'h0000_0001_8000_0000);
    do_op(1, 8'h41, 64'd5);
    do_op(1, 8'h48, 64'd0);
    do_op(1, 8'h1A, 64'd0);
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      do_op(1, 8'h41, a);
      do_op(1, 8'h41, b);
      do_op(1, 8'(8'h46 + $urandom_range(0, 9)), 64'd0);
      do_op(1, 8'h1A, 64'd0);
    end
    do_op(1, 8'h51, 64'd0);

    // 64-bit instance: i64.eq on equal pushes.
    do_op(0, 8'h42, 64'd5);
    do_op(0, 8'h42, 64'd5);
    do_op(0, 8'h51, 64'd0);
    do_op(0, 8'h1A, 64'd0);
    // Signed vs unsigned 64-bit less-than.
    do_op(0, 8'h42, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(0, 8'h42, 64'd1);
    do_op(0, 8'h53, 64'd0);
    do_op(0, 8'h1A, 64'd0);
    do_op(0, 8'h42, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(0, 8'h42, 64'd1);
    do_op(0, 8'h54, 64'd0);
    do_op(0, 8'h1A, 64'd0);
    // i32.const truncation, i32.lt_s, then i32.eqz.
    do_op(0, 8'h41, 64'h0000_0001_8000_0000);
    do_op(0, 8'h41, 64'd0);
    do_op(0, 8'h48, 64'd0);
    do_op(0, 8'h45, 64'd0);
    do_op(0, 8'h1A, 64'd0);

    // Random compares; i32 ops see 64-bit operands with live upper bits.
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      pick = $urandom_range(0, 3);
      if (pick == 0) b = a;
      else if (pick == 1) b = {$urandom, a[31:0]};
      else b = {$urandom, $urandom};
      do_op(0, 8'h42, a);
      do_op(0, 8'h42, b);
      pick = $urandom_range(0, 21);
      if (pick < 10) op = 8'(8'h46 + pick);
      else if (pick < 20) op = 8'(8'h51 + pick - 10);
      else op = (pick == 20) ? 8'h45 : 8'h50;
      do_op(0, op, 64'd0);
      if (op == 8'h45 || op == 8'h50) do_op(0, 8'h1A, 64'd0);
      do_op(0, 8'h1A, 64'd0);
    end

    // Fill, compare at sp==DEPTH, refill, then overflow.
    do_op(0, 8'h42, 64'd10);
    do_op(0, 8'h42, 64'd20);
    do_op(0, 8'h42, 64'd30);
    do_op(0, 8'h42, 64'hFFFF_FFFF_0000_0040);
    do_op(0, 8'h4A, 64'd0);
    do_op(0, 8'h42, 64'd77);
    do_op(0, 8'h42, 64'd88);
    // Trap is sticky: further requests are not accepted.
    drive(0, 1'b1, 8'h42, 64'd99);
    repeat (4) begin
      @(negedge clk);
      check("blk_ready", 64'(u64_if.op_ready), 64'd0);
      check("blk_done", 64'(u64_if.op_done), 64'd0);
      check("blk_sp", 64'(sp64), 64'd4);
      check("blk_trap", 64'(u64_if.trap), 64'd2);
    end
    drive(0, 1'b0, 8'h00, 64'd0);

    apply_reset();
    do_op(0, 8'h1A, 64'd0);
    apply_reset();
    do_op(0, 8'h60, 64'd0);
    apply_reset();

    // Reset asserted during the EXEC cycle of a compare.
    do_op(0, 8'h42, 64'd7);
    do_op(0, 8'h42, 64'd9);
    drive(0, 1'b1, 8'h53, 64'd0);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00, 64'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_ready", 64'(u64_if.op_ready), 64'd0);
    check("mid_empty", 64'(u64_if.result_empty), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("mid_done", 64'(u64_if.op_done), 64'd0);
    check("mid_result", u64_if.result, 64'd0);
    check("mid_sp", 64'(sp64), 64'd0);
    reset = 1'b1;
    model_clear();
    #1;
    check("mid_rel_ready", 64'(u64_if.op_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("mid_no_done", 64'(u64_if.op_done), 64'd0);
    end
    check("mid_empty_after", 64'(u64_if.result_empty), 64'd1);
    check("mid_queue_empty", 64'(exp_q64.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
